rr_arbiter4: RTL and testbench

Four-way round-robin arbiter that shares a single 2-to-4 decoded resource select among four requesters. It registers a 2-bit grant index, drives the one-hot decoded grant (index 0 → 4'b0001 … index 3 → 4'b1000), and holds the grant until the holder releases it. A hold limit forces rotation so that no requester can starve the others. It sits between the requesting agents and the decoded select lines of the shared resource.

---
 rtl/rr_arbiter4.sv | 136 +++++++++++++
 tb/tb_rr_arbiter4.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// rr_arbiter4 -- four-way round-robin arbiter with grant hold and forced rotation.
//
// One requester at a time owns a shared resource whose select lines are the
// one-hot grant. The holder keeps the grant until it drops its request, the
// arbiter is disabled, or it has held for MAX_HOLD cycles while another
// requester waits. In the last case the grant rotates to the next waiting
// requester.
//
// Parameters:
//   MAX_HOLD  consecutive grant cycles before forced rotation (1..255)
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   en       in   enable; low drops any grant and blocks new grants
//   req[3:0] in   request lines, held high while wanting/using the resource
//   gnt[3:0] out  registered one-hot grant, zero when idle
//   gnt_idx  out  registered index of the holder (holds last value when idle)
//   busy     out  high while a grant is active
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       busy
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] gnt_q, gnt_d;

  function automatic logic [3:0] dec(input logic [1:0] i);
    dec = 4'b0001 << i;
  endfunction

  // Rotating priority scan: returns {found, index}. The loop walks from the
  // lowest priority position to the highest so the highest set one wins.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] c;
    pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      c = p + 2'(k);
      if (r[c]) pick = {1'b1, c};
    end
  endfunction

  logic [1:0] nxt_ptr;
  logic [2:0] arb_idle, arb_rel, arb_rot;

  assign nxt_ptr  = idx_q + 2'd1;
  assign arb_idle = pick(req, ptr_q);
  assign arb_rel  = pick(req, nxt_ptr);
  // Holder masked out: only competitors are eligible for a forced rotation.
  // Its found bit doubles as "someone else is waiting".
  assign arb_rot  = pick(req & ~dec(idx_q), nxt_ptr);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (en && arb_idle[2]) begin
          state_d = GRANT;
          idx_d   = arb_idle[1:0];
          gnt_d   = dec(arb_idle[1:0]);
          hold_d  = 8'd1;
        end
      end
      GRANT: begin
        if (!en) begin
          // Disable wins over everything; ptr stays where it was.
          state_d = IDLE;
          gnt_d   = 4'b0000;
          hold_d  = 8'd0;
        end else if (!req[idx_q]) begin
          // Release: re-arbitrate this same edge for a zero-bubble handover.
          ptr_d = nxt_ptr;
          if (arb_rel[2]) begin
            idx_d  = arb_rel[1:0];
            gnt_d  = dec(arb_rel[1:0]);
            hold_d = 8'd1;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            hold_d  = 8'd0;
          end
        end else if (hold_q == HOLD_MAX && arb_rot[2]) begin
          ptr_d  = nxt_ptr;
          idx_d  = arb_rot[1:0];
          gnt_d  = dec(arb_rot[1:0]);
          hold_d = 8'd1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        hold_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      idx_q   <= 2'd0;
      hold_q  <= 8'd0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign busy    = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 (MAX_HOLD = 4). Each step drives inputs on
// the falling edge and queues the hand-computed response expected after the
// next rising edge; the monitor pops and compares one entry per rising edge.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int vec_id = 0;

  typedef struct {
    int         id;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       busy;
    logic       chk_idx;
  } exp_t;

  exp_t q[$];

  rr_arbiter4 #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic e, input logic [3:0] rq,
                      input logic [3:0] eg, input logic [1:0] ei,
                      input logic eb, input logic ci);
    exp_t x;
    @(negedge clk);
    rst = r;
    en  = e;
    req = rq;
    x.id = vec_id; x.gnt = eg; x.idx = ei; x.busy = eb; x.chk_idx = ci;
    vec_id++;
    q.push_back(x);
  endtask

  task automatic chk_now(input string name, input logic [3:0] eg,
                         input logic [1:0] ei, input logic eb);
    n_vec++;
    if (gnt !== eg || busy !== eb || gnt_idx !== ei) begin
      n_err++;
      $display("FAIL %s: gnt=%b idx=%0d busy=%b, want gnt=%b idx=%0d busy=%b",
               name, gnt, gnt_idx, busy, eg, ei, eb);
    end
  endtask

  // Monitor: one compare per rising edge when a response is pending.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        n_vec++;
        if (gnt !== x.gnt || busy !== x.busy || (x.chk_idx && gnt_idx !== x.idx)) begin
          n_err++;
          $display("FAIL vec%0d: gnt=%b idx=%0d busy=%b, want gnt=%b idx=%0d busy=%b",
                   x.id, gnt, gnt_idx, busy, x.gnt, x.idx, x.busy);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; req = 4'b1111;
    #1 chk_now("reset_async", 4'b0000, 2'd0, 1'b0);

    // Held in reset with all requests up.
    step(1, 1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1);
    step(1, 1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1);
    // First edge after release grants index 0.
    step(0, 1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1);

    // Round robin with back-to-back handover: 0,1,2,3,0.
    step(0, 1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1);
    step(0, 1, 4'b1110, 4'b0010, 2'd1, 1'b1, 1'b1);
    step(0, 1, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1);
    step(0, 1, 4'b1101, 4'b0100, 2'd2, 1'b1, 1'b1);
    step(0, 1, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b1);
    step(0, 1, 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b1);
    step(0, 1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b1);
    step(0, 1, 4'b0111, 4'b0001, 2'd0, 1'b1, 1'b1);

    // Index 0 releases to idle (ptr=1); req=1001 skips 1,2 -> 3, then 0.
    step(0, 1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(0, 1, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b1);
    step(0, 1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
    step(0, 1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Forced rotation: 2 holds exactly 4 cycles while 0 waits, then 0.
    step(0, 1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
    step(0, 1, 4'b0101, 4'b0100, 2'd2, 1'b1, 1'b1);
    step(0, 1, 4'b0101, 4'b0100, 2'd2, 1'b1, 1'b1);
    step(0, 1, 4'b0101, 4'b0100, 2'd2, 1'b1, 1'b1);
    step(0, 1, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b1);
    step(0, 1, 4'b0101, 4'b0001, 2'd0, 1'b1, 1'b1);
    // Previous holder re-competes normally after 0 releases (ptr=1 -> 2).
    step(0, 1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);

    // Lone holder keeps the grant; counter saturates, so a competitor
    // appearing afterwards causes rotation on the very next edge.
    for (int i = 0; i < 20; i++)
      step(0, 1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
    step(0, 1, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b1);

    // Disable mid-grant (ptr=3), then re-enable with req=0010.
    step(0, 0, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(0, 1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1);
    // ptr unchanged by disable: from ptr=3 with req=0110 the winner is 1.
    step(0, 1, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b1);
    step(0, 0, 4'b0110, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(0, 1, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b1);
    // Disable also blocks new grants from idle.
    step(0, 0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(0, 0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    // Re-enable from idle with ptr=3.
    step(0, 1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b1);

    // Reset pulse between edges clears outputs immediately.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_now("reset_midgrant", 4'b0000, 2'd0, 1'b0);
    #1 rst = 1'b0;
    // Arbitration restarts at ptr=0.
    step(0, 1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1);
    step(0, 1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d responses pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
